vote_tally_ctrl: RTL and testbench

//  Parametrised N-candidate ballot counter with officer-armed one-vote-per-ballot control.

---
 rtl/vote_pkg.sv | 15 +
 rtl/vote_onehot_enc.sv | 25 ++
 rtl/vote_tally_ctrl.sv | 151 +++++++++++++++
 tb/tb_vote_tally_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and defaults for the vote tally controller.
// Ballot FSM state encoding and default sizing constants.
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    REJ_WAIT,
    REL_WAIT
  } vote_state_t;

  localparam int N_CAND_DEF  = 4;
  localparam int COUNT_W_DEF = 8;

endpackage

// File: rtl/vote_onehot_enc.sv
// Combinational button-vector classifier: zero / one-hot / index.
// Index is only meaningful when is_onehot is set.
module vote_onehot_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0]         vec,
  output logic                 is_zero,
  output logic                 is_onehot,
  output logic [$clog2(N)-1:0] index
);

  localparam int IW = $clog2(N);

  always_comb begin
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) index = index | IW'(i);
    end
  end

  assign is_zero   = (vec == '0);
  assign is_onehot = !is_zero &&
                     ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/vote_tally_ctrl.sv
// N-candidate ballot counter with one-vote-per-arm control.
// Optional reject counter: define VOTE_TALLY_INVALID_CNT_EN.
module vote_tally_ctrl
  import vote_pkg::*;
#(
  parameter int N_CAND  = N_CAND_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              mode,
  input  logic                              ballot_arm,
  input  logic [N_CAND-1:0]                 vote_valid,
  output logic                              ballot_ready,
  output logic                              vote_ack,
  output logic                              vote_rej,
  output logic [$clog2(N_CAND)-1:0]         vote_cand,
  output logic [N_CAND*COUNT_W-1:0]         counts,
  output logic [COUNT_W+$clog2(N_CAND)-1:0] total_votes,
  output logic                              sat_flag
`ifdef VOTE_TALLY_INVALID_CNT_EN
  ,
  output logic [COUNT_W-1:0]                invalid_cnt
`endif
);

  localparam int TOT_W = COUNT_W + $clog2(N_CAND);
  localparam int IW    = $clog2(N_CAND);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = 1;
  localparam logic [TOT_W-1:0]   TOT_ONE = 1;

  vote_state_t state;

  logic          is_zero;
  logic          is_onehot;
  logic [IW-1:0] index;
  logic          accept;
  logic          reject;
  logic [N_CAND-1:0] inc;
  logic [N_CAND-1:0] sat_hit;
  logic [TOT_W-1:0]  total;

  vote_onehot_enc #(
    .N(N_CAND)
  ) u_enc (
    .vec      (vote_valid),
    .is_zero  (is_zero),
    .is_onehot(is_onehot),
    .index    (index)
  );

  // Result mode aborts an open ballot before any press is honoured.
  assign accept = (state == ARMED) && !mode && is_onehot;
  assign reject = (state == ARMED) && !mode &&
                  !is_zero && !is_onehot;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      ballot_ready <= 1'b0;
      vote_ack     <= 1'b0;
      vote_rej     <= 1'b0;
      vote_cand    <= '0;
    end else begin
      vote_ack <= 1'b0;
      vote_rej <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!mode && ballot_arm) begin
            state        <= ARMED;
            ballot_ready <= 1'b1;
          end
        end
        ARMED: begin
          if (mode) begin
            state        <= IDLE;
            ballot_ready <= 1'b0;
          end else if (accept) begin
            state        <= REL_WAIT;
            ballot_ready <= 1'b0;
            vote_ack     <= 1'b1;
            vote_cand    <= index;
          end else if (reject) begin
            state    <= REJ_WAIT;
            vote_rej <= 1'b1;
          end
        end
        REJ_WAIT: begin
          if (mode) begin
            state        <= IDLE;
            ballot_ready <= 1'b0;
          end else if (is_zero) begin
            state <= ARMED;
          end
        end
        REL_WAIT: begin
          if (is_zero) state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          ballot_ready <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N_CAND; i++) begin : g_tally
    logic [COUNT_W-1:0] cnt;
    logic               hit;

    assign hit        = accept && vote_valid[i];
    assign inc[i]     = hit && (cnt != CNT_MAX);
    assign sat_hit[i] = hit && (cnt == CNT_MAX);

    always_ff @(posedge clock) begin
      if (reset)       cnt <= '0;
      else if (inc[i]) cnt <= cnt + CNT_ONE;
    end

    assign counts[i*COUNT_W +: COUNT_W] =
      mode ? cnt : '0;
  end

  // Total only moves with a real increment, so it always equals the sum.
  always_ff @(posedge clock) begin
    if (reset) begin
      total    <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (|inc)     total    <= total + TOT_ONE;
      if (|sat_hit) sat_flag <= 1'b1;
    end
  end

  assign total_votes = mode ? total : '0;

`ifdef VOTE_TALLY_INVALID_CNT_EN
  logic [COUNT_W-1:0] rej_cnt;

  always_ff @(posedge clock) begin
    if (reset)
      rej_cnt <= '0;
    else if (reject && rej_cnt != CNT_MAX)
      rej_cnt <= rej_cnt + CNT_ONE;
  end

  assign invalid_cnt = mode ? rej_cnt : '0;
`endif

endmodule

// File: tb/tb_vote_tally_ctrl.sv
// Randomized and directed bench for vote_tally_ctrl.
// Reference model tracks ballots and tallies with plain integers.
module tb_vote_tally_ctrl;

  localparam int N  = 4;
  localparam int CW = 2;
  localparam int TW = CW + $clog2(N);
  localparam int IW = $clog2(N);
  localparam int MAXC = (1 << CW) - 1;

  localparam int P_IDLE = 0;
  localparam int P_OPEN = 1;
  localparam int P_REJ  = 2;
  localparam int P_REL  = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mode = 1'b0;
  logic          ballot_arm = 1'b0;
  logic [N-1:0]  vote_valid = '0;
  logic          ballot_ready;
  logic          vote_ack;
  logic          vote_rej;
  logic [IW-1:0] vote_cand;
  logic [N*CW-1:0] counts;
  logic [TW-1:0] total_votes;
  logic          sat_flag;
`ifdef VOTE_TALLY_INVALID_CNT_EN
  logic [CW-1:0] invalid_cnt;
`endif

  vote_tally_ctrl #(
    .N_CAND (N),
    .COUNT_W(CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mode        (mode),
    .ballot_arm  (ballot_arm),
    .vote_valid  (vote_valid),
    .ballot_ready(ballot_ready),
    .vote_ack    (vote_ack),
    .vote_rej    (vote_rej),
    .vote_cand   (vote_cand),
    .counts      (counts),
    .total_votes (total_votes),
    .sat_flag    (sat_flag)
`ifdef VOTE_TALLY_INVALID_CNT_EN
    ,
    .invalid_cnt (invalid_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acks  = 0;

  int phase;
  int tally [N];
  int m_inv;
  bit m_sat;
  bit e_ack;
  bit e_rej;
  int e_cand;

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    phase = P_IDLE;
    for (int i = 0; i < N; i++) tally[i] = 0;
    m_inv = 0;
    m_sat = 0;
    e_ack = 0;
    e_rej = 0;
    e_cand = 0;
  endfunction

  function automatic void model_step(input bit m,
                                     input bit a,
                                     input logic [N-1:0] v);
    int pressed;
    pressed = $countones(v);
    e_ack = 0;
    e_rej = 0;
    case (phase)
      P_IDLE: if (!m && a) phase = P_OPEN;
      P_OPEN: begin
        if (m) phase = P_IDLE;
        else if (pressed == 1) begin
          for (int i = 0; i < N; i++)
            if (v[i]) e_cand = i;
          if (tally[e_cand] == MAXC) m_sat = 1;
          else tally[e_cand]++;
          e_ack = 1;
          phase = P_REL;
        end else if (pressed > 1) begin
          e_rej = 1;
          if (m_inv < MAXC) m_inv++;
          phase = P_REJ;
        end
      end
      P_REJ: begin
        if (m) phase = P_IDLE;
        else if (pressed == 0) phase = P_OPEN;
      end
      default: if (pressed == 0) phase = P_IDLE;
    endcase
  endfunction

  task automatic compare(input bit m);
    int sum;
    int got_c;
    sum = 0;
    check("ack", vote_ack, e_ack);
    check("rej", vote_rej, e_rej);
    check("ready", ballot_ready,
          (phase == P_OPEN || phase == P_REJ));
    if (e_ack) check("cand", vote_cand, e_cand);
    for (int i = 0; i < N; i++) begin
      got_c = int'(counts[i*CW +: CW]);
      check($sformatf("count%0d", i), got_c,
            m ? tally[i] : 0);
      sum += tally[i];
    end
    check("total", total_votes, m ? sum : 0);
    check("sat", sat_flag, m_sat);
`ifdef VOTE_TALLY_INVALID_CNT_EN
    check("inv", invalid_cnt, m ? m_inv : 0);
`endif
    if (vote_ack) n_acks++;
  endtask

  task automatic step(input bit m, input bit a,
                      input logic [N-1:0] v);
    mode = m;
    ballot_arm = a;
    vote_valid = v;
    @(posedge clock);
    if (reset) model_clear();
    else model_step(m, a, v);
    #1;
    compare(m);
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    reset = 1'b1;
    step(1'b1, 1'b0, v);
    reset = 1'b0;
  endtask

  task automatic vote(input int c);
    logic [N-1:0] v;
    v = '0;
    v[c] = 1'b1;
    step(0, 1, '0);
    step(0, 0, v);
    step(0, 0, '0);
  endtask

  logic [N-1:0] rv;
  int sel;

  initial begin
    model_clear();
    do_reset('0);
    step(1, 0, '0);
    check("rst_total", total_votes, 0);

    // 1: held press counts once
    n_acks = 0;
    step(0, 1, '0);
    repeat (5) step(0, 0, 4'b0100);
    step(0, 0, '0);
    step(1, 0, '0);
    check("t1_acks", n_acks, 1);
    check("t1_tally2", counts[5:4], 1);
    check("t1_total", total_votes, 1);

    // 2: multi-press rejected, then retry
    step(0, 1, '0);
    step(0, 0, 4'b1001);
    step(0, 0, 4'b1001);
    step(0, 0, '0);
    step(0, 0, 4'b1000);
    step(0, 0, '0);
    step(1, 0, '0);
    check("t2_tally3", counts[7:6], 1);

    // 3: no arm, and arm ignored in result mode
    step(0, 0, 4'b0010);
    step(0, 0, '0);
    step(1, 1, '0);
    step(1, 0, '0);
    check("t3_ready", ballot_ready, 0);

    // 4: saturation on cand1
    n_acks = 0;
    repeat (5) vote(1);
    step(1, 0, '0);
    check("t4_acks", n_acks, 5);
    check("t4_tally1", counts[3:2], 3);
    check("t4_sat", sat_flag, 1);

    // 5: abort by mode, reset in REL_WAIT
    step(0, 1, '0);
    step(1, 0, 4'b0001);
    step(0, 0, 4'b0001);
    step(0, 0, '0);
    step(0, 1, '0);
    step(0, 0, 4'b0001);
    do_reset(4'b0001);
    check("t5_ack", vote_ack, 0);
    check("t5_total", total_votes, 0);
    step(0, 0, '0);

    // 6: secrecy and two rejects
    vote(2);
    repeat (2) begin
      step(0, 1, '0);
      step(0, 0, 4'b0110);
      step(0, 0, '0);
      step(1, 0, '0);
    end
    step(0, 0, '0);
    check("t6_masked", counts, 0);
    step(1, 0, '0);
    check("t6_total", total_votes, 1);
`ifdef VOTE_TALLY_INVALID_CNT_EN
    check("t6_inv", invalid_cnt, 2);
`endif

    do_reset('0);
    for (int k = 0; k < 4000; k++) begin
      sel = $urandom_range(0, 9);
      rv = '0;
      if (sel < 4) rv[$urandom_range(0, N-1)] = 1'b1;
      else if (sel < 6) rv = N'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        do_reset(rv);
      end else begin
        step(($urandom_range(0, 9) == 0),
             ($urandom_range(0, 2) == 0), rv);
      end
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
